// File: rtl/convertidor_bcd_serie.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Optional two's-complement input; result and sign are held until the next conversion.
module convertidor_bcd_serie #(
    parameter int ANCHO     = 8,
    parameter int DIGITOS   = 3,
    parameter int CON_SIGNO = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inicio,
    input  logic [ANCHO-1:0]       dato,
    output logic                   ocupado,
    output logic                   listo,
    output logic [4*DIGITOS-1:0]   decimal,
    output logic                   signo
);

    localparam int CW = $clog2(ANCHO);
    localparam logic [CW-1:0] CNT_INI = CW'(ANCHO - 1);

    function automatic logic [127:0] pot10(input int n);
        logic [127:0] r;
        r = 128'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 128'd10;
        end
        return r;
    endfunction

    localparam logic [127:0] LIMITE = pot10(DIGITOS);
    localparam logic [127:0] MAXIMO = (128'd1 << ANCHO) - 128'd1;

    generate
        if ((ANCHO < 4) || (ANCHO > 32) || (LIMITE <= MAXIMO)) begin : g_param_invalido
            $error("convertidor_bcd_serie: ANCHO must be 4..32 and 10^DIGITOS must exceed 2^ANCHO-1");
        end
    endgenerate

    // Per-digit +3 correction; digits are independent, so no carry ripples between them.
    function automatic logic [4*DIGITOS-1:0] corrige(input logic [4*DIGITOS-1:0] b);
        logic [4*DIGITOS-1:0] r;
        r = b;
        for (int i = 0; i < DIGITOS; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = b[4*i +: 4];
            end
        end
        return r;
    endfunction

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        DESPLAZA = 2'd1,
        FIN      = 2'd2
    } estado_t;

    estado_t                estado_q, estado_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [ANCHO-1:0]       sr_q, sr_d;
    logic [4*DIGITOS-1:0]   bcd_q, bcd_d;
    logic                   signo_int_q, signo_int_d;
    logic                   ocupado_q, ocupado_d;
    logic                   listo_q, listo_d;
    logic [4*DIGITOS-1:0]   decimal_q, decimal_d;
    logic                   signo_q, signo_d;

    logic                   neg_s;
    logic [ANCHO-1:0]       mag_s;
    logic [4*DIGITOS-1:0]   bcd_corr_s;
    logic [4*DIGITOS-1:0]   bcd_nuevo_s;
    logic [ANCHO-1:0]       sr_nuevo_s;

    // Magnitude of the input and one double-dabble step of the working registers.
    always_comb begin
        neg_s       = (CON_SIGNO != 0) && dato[ANCHO-1];
        mag_s       = neg_s ? (~dato + {{(ANCHO-1){1'b0}}, 1'b1}) : dato;
        bcd_corr_s  = corrige(bcd_q);
        bcd_nuevo_s = {bcd_corr_s[4*DIGITOS-2:0], sr_q[ANCHO-1]};
        sr_nuevo_s  = {sr_q[ANCHO-2:0], 1'b0};
    end

    // Next-state and next-output logic of the conversion FSM.
    always_comb begin
        estado_d    = estado_q;
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        bcd_d       = bcd_q;
        signo_int_d = signo_int_q;
        ocupado_d   = 1'b0;
        listo_d     = 1'b0;
        decimal_d   = decimal_q;
        signo_d     = signo_q;
        case (estado_q)
            REPOSO, FIN: begin
                if (inicio) begin
                    estado_d    = DESPLAZA;
                    cnt_d       = CNT_INI;
                    sr_d        = mag_s;
                    bcd_d       = '0;
                    signo_int_d = neg_s;
                    ocupado_d   = 1'b1;
                end else begin
                    estado_d    = REPOSO;
                end
            end
            DESPLAZA: begin
                sr_d  = sr_nuevo_s;
                bcd_d = bcd_nuevo_s;
                // Last iteration publishes its result directly so it is visible in FIN.
                if (cnt_q == '0) begin
                    estado_d  = FIN;
                    listo_d   = 1'b1;
                    decimal_d = bcd_nuevo_s;
                    signo_d   = signo_int_q;
                end else begin
                    cnt_d     = cnt_q - CW'(1);
                    ocupado_d = 1'b1;
                end
            end
            default: begin
                estado_d = REPOSO;
            end
        endcase
    end

    // State and output registers; reset aborts any conversion in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q    <= REPOSO;
            cnt_q       <= '0;
            sr_q        <= '0;
            bcd_q       <= '0;
            signo_int_q <= 1'b0;
            ocupado_q   <= 1'b0;
            listo_q     <= 1'b0;
            decimal_q   <= '0;
            signo_q     <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            bcd_q       <= bcd_d;
            signo_int_q <= signo_int_d;
            ocupado_q   <= ocupado_d;
            listo_q     <= listo_d;
            decimal_q   <= decimal_d;
            signo_q     <= signo_d;
        end
    end

    assign ocupado = ocupado_q;
    assign listo   = listo_q;
    assign decimal = decimal_q;
    assign signo   = signo_q;

endmodule

// File: tb/tb_convertidor_bcd_serie.sv
// Directed bench for convertidor_bcd_serie: unsigned 8-bit, signed 8-bit and
// unsigned 16-bit instances driven from one clock.
module tb_convertidor_bcd_serie;

    logic        clk;
    logic        rst;

    logic        inicio_u, ocupado_u, listo_u, signo_u;
    logic [7:0]  dato_u;
    logic [11:0] decimal_u;

    logic        inicio_s, ocupado_s, listo_s, signo_s;
    logic [7:0]  dato_s;
    logic [11:0] decimal_s;

    logic        inicio_w, ocupado_w, listo_w, signo_w;
    logic [15:0] dato_w;
    logic [19:0] decimal_w;

    int n_chk;
    int n_pass;

    convertidor_bcd_serie #(.ANCHO(8), .DIGITOS(3), .CON_SIGNO(0)) dut_u (
        .clk(clk), .rst(rst), .inicio(inicio_u), .dato(dato_u),
        .ocupado(ocupado_u), .listo(listo_u), .decimal(decimal_u), .signo(signo_u)
    );

    convertidor_bcd_serie #(.ANCHO(8), .DIGITOS(3), .CON_SIGNO(1)) dut_s (
        .clk(clk), .rst(rst), .inicio(inicio_s), .dato(dato_s),
        .ocupado(ocupado_s), .listo(listo_s), .decimal(decimal_s), .signo(signo_s)
    );

    convertidor_bcd_serie #(.ANCHO(16), .DIGITOS(5), .CON_SIGNO(0)) dut_w (
        .clk(clk), .rst(rst), .inicio(inicio_w), .dato(dato_w),
        .ocupado(ocupado_w), .listo(listo_w), .decimal(decimal_w), .signo(signo_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] ref_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic conv_u(input logic [7:0] d, input logic [11:0] e, input string nm);
        int lat;
        lat = -1;
        inicio_u = 1'b1;
        dato_u   = d;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (k == 1) inicio_u = 1'b0;
            if (listo_u === 1'b1) begin
                lat = k;
                break;
            end
        end
        n_chk++;
        if (lat !== 9) $display("FAIL %s_latency: got %0d expected 9", nm, lat);
        else n_pass++;
        n_chk++;
        if (decimal_u !== e) $display("FAIL %s_decimal: got %h expected %h", nm, decimal_u, e);
        else n_pass++;
        n_chk++;
        if (signo_u !== 1'b0) $display("FAIL %s_signo: got %b expected 0", nm, signo_u);
        else n_pass++;
        @(posedge clk); #1;
        n_chk++;
        if (listo_u !== 1'b0) $display("FAIL %s_listo_pulse: got %b expected 0", nm, listo_u);
        else n_pass++;
    endtask

    task automatic conv_s(input logic [7:0] d, input logic [11:0] e, input logic es, input string nm);
        int lat;
        lat = -1;
        inicio_s = 1'b1;
        dato_s   = d;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (k == 1) inicio_s = 1'b0;
            if (listo_s === 1'b1) begin
                lat = k;
                break;
            end
        end
        n_chk++;
        if (lat !== 9) $display("FAIL %s_latency: got %0d expected 9", nm, lat);
        else n_pass++;
        n_chk++;
        if (decimal_s !== e) $display("FAIL %s_decimal: got %h expected %h", nm, decimal_s, e);
        else n_pass++;
        n_chk++;
        if (signo_s !== es) $display("FAIL %s_signo: got %b expected %b", nm, signo_s, es);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic conv_w(input logic [15:0] d, input logic [19:0] e, input string nm);
        int lat;
        lat = -1;
        inicio_w = 1'b1;
        dato_w   = d;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (k == 1) inicio_w = 1'b0;
            if (listo_w === 1'b1) begin
                lat = k;
                break;
            end
        end
        n_chk++;
        if (lat !== 17) $display("FAIL %s_latency: got %0d expected 17", nm, lat);
        else n_pass++;
        n_chk++;
        if (decimal_w !== e) $display("FAIL %s_decimal: got %h expected %h", nm, decimal_w, e);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        n_chk++;
        if ({ocupado_u, listo_u, signo_u, decimal_u} !== 15'd0)
            $display("FAIL reset_u: got %h expected 0", {ocupado_u, listo_u, signo_u, decimal_u});
        else n_pass++;
        n_chk++;
        if ({ocupado_s, listo_s, signo_s, decimal_s} !== 15'd0)
            $display("FAIL reset_s: got %h expected 0", {ocupado_s, listo_s, signo_s, decimal_s});
        else n_pass++;
        n_chk++;
        if ({ocupado_w, listo_w, signo_w, decimal_w} !== 23'd0)
            $display("FAIL reset_w: got %h expected 0", {ocupado_w, listo_w, signo_w, decimal_w});
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_unsigned();
        conv_u(8'd255, 12'h255, "u255");
        conv_u(8'd0,   12'h000, "u0");
        conv_u(8'd99,  12'h099, "u99");
    endtask

    task automatic test_signed();
        conv_s(8'h80, 12'h128, 1'b1, "s80");
        conv_s(8'hFF, 12'h001, 1'b1, "sFF");
        conv_s(8'h7F, 12'h127, 1'b0, "s7F");
        conv_s(8'h00, 12'h000, 1'b0, "s00");
    endtask

    task automatic test_wide();
        conv_w(16'd65535, 20'h65535, "w65535");
        conv_w(16'd10000, 20'h10000, "w10000");
    endtask

    task automatic test_back_to_back();
        int issued, got, cyc, last_cyc;
        issued   = 1;
        got      = 0;
        cyc      = 0;
        last_cyc = 0;
        inicio_u = 1'b1;
        dato_u   = 8'd0;
        while ((got < 256) && (cyc < 256 * 9 + 50)) begin
            @(posedge clk); #1;
            cyc++;
            inicio_u = 1'b0;
            if (listo_u === 1'b1) begin
                n_chk++;
                if (decimal_u !== ref_bcd(got))
                    $display("FAIL b2b_decimal[%0d]: got %h expected %h", got, decimal_u, ref_bcd(got));
                else n_pass++;
                n_chk++;
                if ((cyc - last_cyc) !== 9)
                    $display("FAIL b2b_period[%0d]: got %0d expected 9", got, cyc - last_cyc);
                else n_pass++;
                last_cyc = cyc;
                got++;
                if (issued < 256) begin
                    inicio_u = 1'b1;
                    dato_u   = 8'(issued);
                    issued++;
                end
            end
        end
        n_chk++;
        if (got !== 256) $display("FAIL b2b_count: got %0d expected 256", got);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_ignored_request();
        int n_listo, bad_ocup, bad_hold;
        conv_u(8'd77, 12'h077, "pre77");
        n_listo  = 0;
        bad_ocup = 0;
        bad_hold = 0;
        inicio_u = 1'b1;
        dato_u   = 8'd255;
        for (int k = 1; k <= 25; k++) begin
            @(posedge clk); #1;
            inicio_u = 1'b0;
            if (k == 4) begin
                inicio_u = 1'b1;
                dato_u   = 8'd7;
            end
            if (listo_u === 1'b1) begin
                n_listo++;
                n_chk++;
                if ((k !== 9) || (decimal_u !== 12'h255))
                    $display("FAIL ign_result: got %h at cycle %0d expected 255 at cycle 9", decimal_u, k);
                else n_pass++;
            end
            if (ocupado_u !== ((k >= 1) && (k <= 8))) bad_ocup++;
            if ((k < 9) && (decimal_u !== 12'h077)) bad_hold++;
        end
        n_chk++;
        if (n_listo !== 1) $display("FAIL ign_listo_count: got %0d expected 1", n_listo);
        else n_pass++;
        n_chk++;
        if (bad_ocup !== 0) $display("FAIL ign_ocupado: got %0d bad cycles expected 0", bad_ocup);
        else n_pass++;
        n_chk++;
        if (bad_hold !== 0) $display("FAIL ign_decimal_hold: got %0d bad cycles expected 0", bad_hold);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int n_listo;
        n_listo  = 0;
        inicio_u = 1'b1;
        dato_u   = 8'd200;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            inicio_u = 1'b0;
            if (listo_u === 1'b1) n_listo++;
            if (k == 5) rst = 1'b1;
        end
        rst = 1'b0;
        n_chk++;
        if ({ocupado_u, listo_u, decimal_u} !== 14'd0)
            $display("FAIL rstmid_state: got %h expected 0", {ocupado_u, listo_u, decimal_u});
        else n_pass++;
        for (int k = 7; k <= 25; k++) begin
            @(posedge clk); #1;
            if (listo_u === 1'b1) n_listo++;
        end
        n_chk++;
        if (n_listo !== 0) $display("FAIL rstmid_no_listo: got %0d expected 0", n_listo);
        else n_pass++;
        conv_u(8'd42, 12'h042, "post42");
    endtask

    initial begin
        n_chk    = 0;
        n_pass   = 0;
        rst      = 1'b1;
        inicio_u = 1'b0;
        inicio_s = 1'b0;
        inicio_w = 1'b0;
        dato_u   = 8'd0;
        dato_s   = 8'd0;
        dato_w   = 16'd0;
        test_reset();
        test_unsigned();
        test_signed();
        test_wide();
        test_back_to_back();
        test_ignored_request();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
